pc_gen: RTL

//  Parametrised program-counter generator for the fetch stage. Selects the next PC from
//  one of five sources: increment, branch, jump, register-indirect jump, or return. Holds
//  on stall. Keeps a circular return-address stack (RAS) so that call/return pairs

---
 rtl/pc_gen_if.sv | 31 +++
 rtl/pc_gen.sv | 98 +++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: control and target inputs toward the generator, PC and RAS status back.
// Latency: none, wires only.
// Backpressure: stall is the only flow control and is carried here.
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [2:0]       pc_src;
  logic             push;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] jump_address;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] inc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;
  logic             ras_overflow;
  logic             misalign;

  modport master (
    output stall, pc_src, push, imm, jump_address, rs1,
    input  pc, pc_plus4, inc, ras_empty, ras_full, ras_underflow, ras_overflow, misalign
  );

  modport slave (
    input  stall, pc_src, push, imm, jump_address, rs1,
    output pc, pc_plus4, inc, ras_empty, ras_full, ras_underflow, ras_overflow, misalign
  );
endinterface

// File: rtl/pc_gen.sv
// Next-PC select (inc/branch/jump/reg-jump/return) with a circular return-address stack.
// Latency: target chosen in cycle n is on pc in cycle n+1, no bubbles.
// Backpressure: stall freezes pc, RAS and pointers; the pulses read 0 on the next cycle.
module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input logic   clk,
  input logic   rst,
  pc_gen_if.slave bus
);
  localparam int         PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

  localparam logic [2:0] SRC_INC = 3'b000;
  localparam logic [2:0] SRC_BR  = 3'b001;
  localparam logic [2:0] SRC_JMP = 3'b010;
  localparam logic [2:0] SRC_RJ  = 3'b011;
  localparam logic [2:0] SRC_RET = 3'b100;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] rj_sum;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_q;
  logic [PW:0]      count_q;
  logic             ras_empty;
  logic             ras_full;
  logic             pop;
  logic             misalign_q;
  logic             underflow_q;
  logic             overflow_q;

  assign pc_plus4  = pc_q + WIDTH'(4);
  assign rj_sum    = bus.rs1 + bus.imm;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == FULL_CNT);
  assign pop       = (bus.pc_src == SRC_RET);

  always_comb begin
    target_raw = pc_plus4;
    case (bus.pc_src)
      SRC_INC: target_raw = pc_plus4;
      SRC_BR:  target_raw = pc_q + (bus.imm << 2);
      SRC_JMP: target_raw = bus.jump_address << 2;
      SRC_RJ:  target_raw = {rj_sum[WIDTH-1:1], 1'b0};
      // An empty stack falls through to sequential fetch.
      SRC_RET: target_raw = ras_empty ? pc_plus4 : ras_mem[top_q];
      default: target_raw = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_VECTOR;
      top_q       <= '0;
      count_q     <= '0;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.stall) begin
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pc_q        <= {target_raw[WIDTH-1:2], 2'b00};
      misalign_q  <= target_raw[1];
      underflow_q <= pop && !bus.push && ras_empty;
      overflow_q  <= bus.push && !pop && ras_full;
      // Pop+push swaps the top in place, so pointer and count stay put.
      if (bus.push && !pop) begin
        top_q <= top_q + 1'b1;
        if (!ras_full) count_q <= count_q + 1'b1;
      end else if (pop && !bus.push && !ras_empty) begin
        top_q   <= top_q - 1'b1;
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.stall && bus.push) begin
      if (pop) ras_mem[top_q]        <= pc_plus4;
      else     ras_mem[top_q + 1'b1] <= pc_plus4;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.inc           = pc_plus4 >> 2;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_underflow = underflow_q;
  assign bus.ras_overflow  = overflow_q;
  assign bus.misalign      = misalign_q;
endmodule
